router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- Per-port output buffer of the 1x3 packet router. Sits directly downstream of the synchronizer: one instance per destination port.
- Consumes that port's `wr_en` bit and `soft_reset_N`. Returns `full_N` and `empty_N`.
- Stores header/payload/parity bytes with a header-tag bit. Tracks packet boundaries on the read side so the output port knows when a packet is finished.

Parameters:
- DATA_WIDTH, 8, width of one packet byte.
- DEPTH, 16, number of storage entries; must be a power of two.
- ADDR_WIDTH, 4, log2(DEPTH); pointers are ADDR_WIDTH+1 bits wide.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- soft_reset  input  1  synchronous flush from the synchronizer (read timeout); active-high.
- wr_en  input  1  write strobe (one bit of the synchronizer's `wr_en` bus).
- lfd_state  input  1  high while the byte on `din` is the packet header.
- din  input  DATA_WIDTH  byte to store.
- rd_en  input  1  read strobe from the destination.
- dout  output  DATA_WIDTH  registered read data.
- full  output  1  no free entry.
- empty  output  1  no stored entry.
- pkt_active  output  1  high while read-side packet byte count is non-zero.

Behaviour:
- Storage: DEPTH entries of DATA_WIDTH+1 bits, holding `{lfd_state, din}`.
  - Bit DATA_WIDTH is the header tag.
  - Memory contents are not reset.
- Reset priority: `rst` > `soft_reset` > normal operation. Both act in the same cycle they are sampled high, and produce identical effects:
  - `wr_ptr`, `rd_ptr`, `pkt_count` and `dout` are cleared to 0.
  - `empty` = 1, `full` = 0, `pkt_active` = 0.
  - Any write or read in that cycle is discarded.
- Pointers:
  - `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits wide and wrap naturally modulo 2*DEPTH.
  - `empty` = (`wr_ptr` == `rd_ptr`).
  - `full` = MSBs differ and the lower ADDR_WIDTH bits are equal.
  - Both flags are combinational from the registered pointers, so they are valid in the cycle after a pointer update.
- Write: when `wr_en` && !`full`, `mem[wr_ptr[ADDR_WIDTH-1:0]] <= {lfd_state, din}` and `wr_ptr` increments. `wr_en` while full is ignored (no overwrite, no pointer change).
- Read: when `rd_en` && !`empty`:
  - `dout <= mem[rd_ptr][DATA_WIDTH-1:0]` and `rd_ptr` increments. Latency is 1 cycle from the `rd_en` edge to valid `dout`.
  - `rd_en` while empty is ignored; `dout` holds its value.
- Simultaneous read and write:
  - Both proceed when neither is blocked; the occupancy is unchanged.
  - When full, the read proceeds and the write is blocked (the flag is from before the edge).
  - When empty, the write proceeds and the read is blocked; there is no fall-through.
- Packet counter:
  - `pkt_count` is 7 bits.
  - On a successful read of a tagged entry: `pkt_count <= mem[rd_ptr][7:2] + 1`. This is the payload length from header bits [7:2], plus 1 for the parity byte.
  - On a successful read of an untagged entry with `pkt_count` != 0: `pkt_count` decrements.
  - An untagged read with `pkt_count` == 0 leaves it at 0 (stray byte); `dout` is still updated.
  - `pkt_active` = (`pkt_count` != 0).
- Maximum packet is 1 + 63 + 1 = 65 bytes, larger than DEPTH. The writer stalls on `full`; no data is lost.

Decomposition:
- Shared package `router_pkg` holds:
  - DATA_WIDTH, FIFO_DEPTH, FIFO_ADDR_WIDTH.
  - HDR_TAG_BIT index.
  - Header field positions: ADDR field [1:0], LEN field [7:2].
  - PARITY_BYTES = 1.
  - The synchronizer's timeout constant of 30 cycles.
- No sub-module: the storage array is inline. The pointer/flag logic is small enough to stay in one module.

Test Plan:
- Reset: assert `rst` for 2 cycles -> `empty`=1, `full`=0, `dout`=0x00, `pkt_active`=0. Then write one byte with `rst` high -> `empty` stays 1.
- Fill/overflow: write 0x01..0x10 (16 bytes), then 0xAA -> `full`=1 after the 16th write. Reading 16 times returns 0x01..0x10 in order; 0xAA is never seen. `empty`=1 after the 16th read.
- Packet tracking: write header 0x0C (len 3) with `lfd_state`=1, then 0x11, 0x22, 0x33 and parity 0x3E -> after the header read, `pkt_count`=4 and `pkt_active`=1. After the 4th following read, `pkt_active`=0 and `dout`=0x3E.
- Simultaneous read+write: with 16 entries (full), assert `rd_en` and `wr_en` (din 0x55) together -> oldest byte read, write dropped, `full`=0 next cycle. With 0 entries, assert both together -> write lands, `dout` unchanged, `empty`=0.
- Soft reset mid-packet: after the header and 2 payload bytes have been read, pulse `soft_reset` one cycle -> `empty`=1, `pkt_active`=0, `dout`=0x00 next cycle. A subsequent new packet reads correctly from entry 0.
- Pointer wrap: stream 40 bytes with interleaved reads, keeping occupancy between 1 and 15 -> data order is preserved across both pointer wraps, and `full`/`empty` are never falsely asserted.

Source files
------------

// File: rtl/router_pkg.sv
// Constants shared by the 1x3 packet router blocks. This covers the byte
// width, the output FIFO geometry and the header field layout.
package router_pkg;

   localparam int DATA_WIDTH      = 8;
   localparam int FIFO_DEPTH      = 16;
   localparam int FIFO_ADDR_WIDTH = 4;

   localparam int HDR_TAG_BIT = DATA_WIDTH;

   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_MSB  = 7;

   localparam int PARITY_BYTES = 1;
   localparam int PKT_CNT_W    = 7;

   localparam int SYNC_TIMEOUT = 30;

   function automatic logic [PKT_CNT_W-1:0] hdr_remaining(
      input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len
   );
      return PKT_CNT_W'(len) + PKT_CNT_W'(PARITY_BYTES);
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-port output buffer of the packet router. It stores bytes together with
// a header tag and tracks how many bytes of the current packet remain to be read.
module router_fifo
   import router_pkg::*;
#(
   parameter int DATA_WIDTH_P = DATA_WIDTH,
   parameter int DEPTH        = FIFO_DEPTH,
   parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    soft_reset,
   input  logic                    wr_en,
   input  logic                    lfd_state,
   input  logic [DATA_WIDTH_P-1:0] din,
   input  logic                    rd_en,
   output logic [DATA_WIDTH_P-1:0] dout,
   output logic                    full,
   output logic                    empty,
   output logic                    pkt_active
);

   logic [DATA_WIDTH_P:0]  mem [DEPTH];
   logic [ADDR_WIDTH:0]    wr_ptr;
   logic [ADDR_WIDTH:0]    rd_ptr;
   logic [PKT_CNT_W-1:0]   pkt_count;
   logic [DATA_WIDTH_P:0]  rd_word;
   logic                   flush;
   logic                   do_wr;
   logic                   do_rd;

   assign flush   = rst || soft_reset;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];

   assign pkt_active = (pkt_count != '0);

   // Storage is intentionally left unreset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (!flush && do_wr)
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= {lfd_state, din};
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pkt_count <= '0;
         dout      <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= rd_word[DATA_WIDTH_P-1:0];
            // A header reloads the count with the payload length plus parity.
            // An untagged byte read when the count is zero is a stray byte.
            if (rd_word[DATA_WIDTH_P])
               pkt_count <= hdr_remaining(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]);
            else if (pkt_count != '0)
               pkt_count <= pkt_count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo. It checks the DUT against a queue-based
// model of the FIFO contents and of the packet byte count.
module tb_router_fifo;
   import router_pkg::*;

   logic       clk = 1'b0;
   logic       rst, soft_reset, wr_en, lfd_state, rd_en;
   logic [7:0] din;
   logic [7:0] dout;
   logic       full, empty, pkt_active;

   always #5 clk = ~clk;

   router_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .soft_reset (soft_reset),
      .wr_en      (wr_en),
      .lfd_state  (lfd_state),
      .din        (din),
      .rd_en      (rd_en),
      .dout       (dout),
      .full       (full),
      .empty      (empty),
      .pkt_active (pkt_active)
   );

   typedef struct {
      logic [7:0] data;
      int         cnt;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] mq[$];
   int         m_cnt  = 0;
   logic [7:0] m_dout = 8'h00;
   int         checks = 0;
   int         errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock cycle of stimulus: model update, clock edge, then flag checks.
   task automatic cycle(bit r, bit sr, bit w, bit l, logic [7:0] d, bit rd);
      bit         wr_ok, rd_ok;
      logic [8:0] e;
      rst = r; soft_reset = sr; wr_en = w; lfd_state = l; din = d; rd_en = rd;
      if (r || sr) begin
         mq.delete();
         m_cnt  = 0;
         m_dout = 8'h00;
      end else begin
         wr_ok = w && (mq.size() < FIFO_DEPTH);
         rd_ok = rd && (mq.size() != 0);
         if (rd_ok) begin
            e = mq.pop_front();
            if (e[8]) m_cnt = int'(e[7:2]) + PARITY_BYTES;
            else if (m_cnt != 0) m_cnt--;
            m_dout = e[7:0];
            exp_q.push_back('{e[7:0], m_cnt});
         end
         if (wr_ok) mq.push_back({l, d});
      end
      @(posedge clk);
      @(negedge clk);
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == FIFO_DEPTH);
      check("pkt_active", pkt_active, m_cnt != 0);
      check("dout", dout, m_dout);
   endtask

   task automatic wr(bit l, logic [7:0] d);
      cycle(0, 0, 1, l, d, 0);
   endtask

   task automatic rdc();
      cycle(0, 0, 0, 0, 8'h00, 1);
   endtask

   // Monitor: whenever a read is accepted at an edge, compare the result.
   logic fire;
   exp_t x;
   initial begin
      forever begin
         @(posedge clk);
         fire = rd_en && !empty && !rst && !soft_reset;
         @(negedge clk);
         if (fire === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected: got dout %0h expected no read", dout);
            end else begin
               x = exp_q.pop_front();
               if (dout !== x.data || int'(dut.pkt_count) != x.cnt) begin
                  errors++;
                  $display("FAIL rd_data: got dout %0h cnt %0d expected dout %0h cnt %0d",
                           dout, dut.pkt_count, x.data, x.cnt);
               end
            end
         end
      end
   end

   initial begin
      int wrote;
      rst = 1; soft_reset = 0; wr_en = 0; lfd_state = 0; din = 0; rd_en = 0;

      // Reset, including a write attempted while reset is held.
      cycle(1, 0, 0, 0, 8'h00, 0);
      cycle(1, 0, 0, 0, 8'h00, 0);
      cycle(1, 0, 1, 0, 8'h77, 0);
      check("reset_write_dropped", empty, 1);

      // Fill to full, attempt overflow, then drain in order.
      for (int i = 1; i <= 16; i++) wr(0, 8'(i));
      check("full_after_16", full, 1);
      wr(0, 8'hAA);
      for (int i = 0; i < 16; i++) rdc();
      check("empty_after_drain", empty, 1);
      check("last_drained", dout, 8'h10);
      rdc();

      // Packet tracking: header 0x0C means length 3, plus a parity byte.
      wr(1, 8'h0C); wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h3E);
      rdc();
      check("pkt_count_hdr", dut.pkt_count, 4);
      for (int i = 0; i < 4; i++) rdc();
      check("pkt_done_active", pkt_active, 0);
      check("pkt_done_dout", dout, 8'h3E);

      // Simultaneous read and write while full, then while empty.
      for (int i = 0; i < 16; i++) wr(0, 8'($urandom));
      cycle(0, 0, 1, 0, 8'h55, 1);
      check("full_rw_not_full", full, 0);
      for (int i = 0; i < 15; i++) rdc();
      cycle(0, 0, 1, 0, 8'h66, 1);
      check("empty_rw_not_empty", empty, 0);
      rdc();
      check("empty_rw_data", dout, 8'h66);

      // Soft reset partway through a packet, then a fresh packet from entry 0.
      wr(1, 8'h0C); wr(0, 8'hA1); wr(0, 8'hA2); wr(0, 8'hA3); wr(0, 8'hA4);
      rdc(); rdc(); rdc();
      cycle(0, 1, 1, 0, 8'hEE, 1);
      check("srst_dout", dout, 8'h00);
      check("srst_rd_ptr", dut.rd_ptr, 0);
      wr(1, 8'h08); wr(0, 8'hB1); wr(0, 8'hB2); wr(0, 8'hB3);
      for (int i = 0; i < 4; i++) rdc();
      check("srst_new_pkt_done", pkt_active, 0);

      // Stream 40 bytes while keeping occupancy between 1 and 15.
      wrote = 0;
      while (wrote < 40) begin
         if (mq.size() <= 1) begin
            wr(0, 8'($urandom)); wrote++;
         end else if (mq.size() >= 15) begin
            rdc();
         end else begin
            bit w = 1'($urandom);
            cycle(0, 0, w, 0, 8'($urandom), 1'($urandom));
            if (w) wrote++;
         end
      end
      while (mq.size() != 0) rdc();

      // Random traffic with headers, stray bytes and occasional flushes.
      for (int i = 0; i < 400; i++)
         cycle(0, ($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
               8'($urandom), 1'($urandom));

      cycle(0, 0, 0, 0, 8'h00, 0);
      cycle(0, 0, 0, 0, 8'h00, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
